// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: field widths, word layout, opcodes, loader types.
package picomips_pkg;

    localparam int unsigned OPW  = 3;
    localparam int unsigned RAW  = 3;
    localparam int unsigned IMMW = 8;
    localparam int unsigned PAW  = 5;
    localparam int unsigned IW   = OPW + 2 * RAW + IMMW;

    // Bit offsets of each field inside an instruction word {op, rd, rs, imm}
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned RS_LSB  = IMMW;
    localparam int unsigned RD_LSB  = IMMW + RAW;
    localparam int unsigned OP_LSB  = IMMW + 2 * RAW;

    // Highest program-memory address; a non-final word written here overflows
    localparam logic [PAW-1:0] LAST_ADDR = '1;

    // Opcode set shared with the decoder; 3'b110 and 3'b111 are unassigned
    localparam logic [OPW-1:0] OP_NOP   = 3'b000;
    localparam logic [OPW-1:0] OP_ADD   = 3'b001;
    localparam logic [OPW-1:0] OP_ADDI  = 3'b010;
    localparam logic [OPW-1:0] OP_MULI  = 3'b011;
    localparam logic [OPW-1:0] OP_INPUT = 3'b100;
    localparam logic [OPW-1:0] OP_HOLD  = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE,
        ERR
    } ldr_state_t;

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [RAW-1:0]  rd;
        logic [RAW-1:0]  rs;
        logic [IMMW-1:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/prog_loader_if.sv
// Field-set input stream and program-memory write port of the loader.
interface prog_loader_if;
    import picomips_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [OPW-1:0]  in_op;
    logic [RAW-1:0]  in_rd;
    logic [RAW-1:0]  in_rs;
    logic [IMMW-1:0] in_imm;

    logic            pm_we;
    logic [PAW-1:0]  pm_addr;
    logic [IW-1:0]   pm_wdata;

    // Assembler side: produces field sets, observes memory writes
    modport master (
        output in_valid, in_last, in_op, in_rd, in_rs, in_imm,
        input  in_ready, pm_we, pm_addr, pm_wdata
    );

    // Loader side: consumes field sets, drives memory writes
    modport slave (
        input  in_valid, in_last, in_op, in_rd, in_rs, in_imm,
        output in_ready, pm_we, pm_addr, pm_wdata
    );

endinterface

// File: rtl/instr_encoder.sv
// Combinational assembler: packs a field set into a canonical instruction word.
module instr_encoder
    import picomips_pkg::*;
(
    input  instr_fields_t   fields,
    output logic            legal_c,
    output logic [IW-1:0]   word_c
);

    // Keep only the fields each opcode actually uses; unknown opcodes are flagged
    always_comb begin
        legal_c = 1'b1;
        word_c  = '0;
        word_c[OP_LSB +: OPW] = fields.op;
        case (fields.op)
            OP_NOP: begin
                word_c = '0;
            end
            OP_INPUT: begin
                word_c[RD_LSB +: RAW] = fields.rd;
            end
            OP_ADD: begin
                word_c[RD_LSB +: RAW] = fields.rd;
                word_c[RS_LSB +: RAW] = fields.rs;
            end
            OP_ADDI, OP_MULI: begin
                word_c[RD_LSB +: RAW]   = fields.rd;
                word_c[RS_LSB +: RAW]   = fields.rs;
                word_c[IMM_LSB +: IMMW] = fields.imm;
            end
            OP_HOLD: begin
            end
            default: begin
                legal_c = 1'b0;
                word_c  = '0;
            end
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: encodes field sets, writes them to consecutive program-memory
// addresses and releases the core once the final word has been written.
module prog_loader
    import picomips_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    prog_loader_if.slave  bus,
    output logic [PAW:0]  count,
    output logic          cpu_run,
    output logic          err
);

    localparam int unsigned CW = PAW + 1;

    ldr_state_t      state;
    ldr_state_t      state_nx;
    logic [PAW-1:0]  addr;
    logic [IW-1:0]   word_q;
    logic            last_q;
    instr_fields_t   fields;
    logic            enc_legal_c;
    logic [IW-1:0]   enc_word_c;
    logic            accept_c;

    assign fields = '{op: bus.in_op, rd: bus.in_rd, rs: bus.in_rs, imm: bus.in_imm};

    instr_encoder u_enc (
        .fields  (fields),
        .legal_c (enc_legal_c),
        .word_c  (enc_word_c)
    );

    // A start in the same cycle as a handshake discards the field set
    assign accept_c = (state == LOAD) && bus.in_valid && !start;

    assign bus.pm_addr  = addr;
    assign bus.pm_wdata = word_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                if (start) begin
                    state_nx = LOAD;
                end else if (bus.in_valid) begin
                    state_nx = enc_legal_c ? WRITE : ERR;
                end
            end
            WRITE: begin
                if (start) begin
                    state_nx = LOAD;
                end else if (last_q) begin
                    state_nx = DONE;
                end else if (addr == LAST_ADDR) begin
                    state_nx = ERR;
                end else begin
                    state_nx = LOAD;
                end
            end
            DONE, ERR: begin
                if (start) state_nx = LOAD;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.in_ready = 1'b0;
        bus.pm_we    = 1'b0;
        cpu_run      = 1'b0;
        err          = 1'b0;
        case (state)
            LOAD:    bus.in_ready = 1'b1;
            WRITE:   bus.pm_we    = 1'b1;
            DONE:    cpu_run      = 1'b1;
            ERR:     err          = 1'b1;
            default: ;
        endcase
    end

    // Address/count bookkeeping and capture of the accepted word
    always_ff @(posedge clk) begin
        if (reset) begin
            addr   <= '0;
            count  <= '0;
            word_q <= '0;
            last_q <= 1'b0;
        end else begin
            if (start) begin
                addr  <= '0;
                count <= '0;
            end else if (state == WRITE) begin
                addr  <= addr + PAW'(1);
                count <= count + CW'(1);
            end
            if (accept_c && enc_legal_c) begin
                word_q <= enc_word_c;
                last_q <= bus.in_last;
            end
        end
    end

endmodule
